// File: rtl/io_bank_pkg.sv
// Shared address-map helpers for the io_bank memory-mapped I/O register bank.
package io_bank_pkg;

  function automatic int addr_w(input int n_in, input int n_out);
    return $clog2(n_in + n_out + 1);
  endfunction

  function automatic int in_base();
    return 0;
  endfunction

  function automatic int out_base(input int n_in);
    return n_in;
  endfunction

  function automatic int evt_addr(input int n_in, input int n_out);
    return n_in + n_out;
  endfunction

endpackage

// File: rtl/io_bank_input.sv
// One input channel: synchroniser, optional debounce filter, accepted value.
// Debounce filter is built when IO_BANK_DEBOUNCE_EN is defined.
module io_bank_input
  import io_bank_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] val_o,
  output logic             changed_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] val_q;
  logic [WIDTH-1:0] val_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      val_q <= '0;
    end else begin
      sync_q[0] <= raw_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      val_q <= val_d;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef IO_BANK_DEBOUNCE_EN
  localparam int            CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      prev_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      prev_q <= sync_out;
    end
  end

  // Any wiggle, or agreement with the accepted value, restarts the stability count.
  always_comb begin
    val_d = val_q;
    cnt_d = cnt_q + 1'b1;
    if (sync_out != prev_q || sync_out == val_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      val_d = sync_out;
      cnt_d = '0;
    end
  end
`else
  assign val_d = sync_out;
`endif

  // Combinational so the EVT bit sets on the same edge that val updates.
  assign changed_o = (val_d != val_q);
  assign val_o     = val_q;

endmodule

// File: rtl/io_bank.sv
// Memory-mapped I/O bank: synchronised inputs, output registers, sticky W1C event register.
// Define IO_BANK_DEBOUNCE_EN to add a per-channel debounce filter on the inputs.
module io_bank
  import io_bank_pkg::*;
#(
  parameter  int WIDTH       = 16,
  parameter  int N_IN        = 2,
  parameter  int N_OUT       = 3,
  parameter  int SYNC_STAGES = 2,
  parameter  int DEB_CYCLES  = 1000,
  localparam int ADDR_W      = addr_w(N_IN, N_OUT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      address,
  input  logic                   load,
  input  logic [WIDTH-1:0]       in,
  output logic [WIDTH-1:0]       out,
  input  logic [N_IN*WIDTH-1:0]  iIN,
  output logic [N_OUT*WIDTH-1:0] oOUT
);

  localparam int OUT_BASE = out_base(N_IN);
  localparam int EVT_ADDR = evt_addr(N_IN, N_OUT);

  logic [WIDTH-1:0] val [N_IN];
  logic [N_IN-1:0]  changed;
  logic [WIDTH-1:0] out_q [N_OUT];
  logic [WIDTH-1:0] out_d [N_OUT];
  logic [N_IN-1:0]  evt_q;
  logic [N_IN-1:0]  evt_d;
  logic             evt_wr;
  int               addr_i;

  assign addr_i = int'(address);

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    io_bank_input #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES)
    ) u_in (
      .clk       (clk),
      .rst       (rst),
      .raw_i     (iIN[i*WIDTH +: WIDTH]),
      .val_o     (val[i]),
      .changed_o (changed[i])
    );
  end

  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      out_d[j] = out_q[j];
      if (load && addr_i == OUT_BASE + j) out_d[j] = in;
    end
  end

  // Set is OR-ed in after the clear so a same-cycle change is never lost.
  assign evt_wr = load && (addr_i == EVT_ADDR);
  assign evt_d  = (evt_q & ~(evt_wr ? in[N_IN-1:0] : '0)) | changed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < N_OUT; j++) out_q[j] <= '0;
      evt_q <= '0;
    end else begin
      for (int j = 0; j < N_OUT; j++) out_q[j] <= out_d[j];
      evt_q <= evt_d;
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    assign oOUT[j*WIDTH +: WIDTH] = out_q[j];
  end

  always_comb begin
    out = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (addr_i == i) out = val[i];
    end
    for (int j = 0; j < N_OUT; j++) begin
      if (addr_i == OUT_BASE + j) out = out_q[j];
    end
    if (addr_i == EVT_ADDR) out[N_IN-1:0] = evt_q;
  end

endmodule

// File: tb/tb_io_bank.sv
// Directed, table-driven bench for io_bank (WIDTH=16, N_IN=2, N_OUT=3, SYNC_STAGES=2).
module tb_io_bank;

  logic        clk;
  logic        rst;
  logic [2:0]  address;
  logic        load;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic [31:0] iin;
  logic [47:0] oout;

  int n_vec;
  int n_miss;

  io_bank #(
    .WIDTH       (16),
    .N_IN        (2),
    .N_OUT       (3),
    .SYNC_STAGES (2),
    .DEB_CYCLES  (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .address (address),
    .load    (load),
    .in      (wdata),
    .out     (rdata),
    .iIN     (iin),
    .oOUT    (oout)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [2:0]  addr;
    logic [15:0] wdat;
    logic [2:0]  rd_addr;
    logic [15:0] exp_rd;
    logic [47:0] exp_oout;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_rd(input string name, input logic [2:0] a, input logic [15:0] exp);
    address = a;
    #1;
    check(name, {32'h0, rdata}, {32'h0, exp});
  endtask

  initial begin
    n_vec   = 0;
    n_miss  = 0;
    rst     = 1'b1;
    load    = 1'b0;
    address = '0;
    wdata   = '0;
    iin     = '0;

    vecs[0]  = '{1'b1, 3'd3, 16'hBEEF, 3'd3, 16'hBEEF, 48'h0000_BEEF_0000};
    vecs[1]  = '{1'b1, 3'd2, 16'h1234, 3'd2, 16'h1234, 48'h0000_BEEF_1234};
    vecs[2]  = '{1'b1, 3'd4, 16'hA5A5, 3'd4, 16'hA5A5, 48'hA5A5_BEEF_1234};
    vecs[3]  = '{1'b0, 3'd3, 16'h0000, 3'd3, 16'hBEEF, 48'hA5A5_BEEF_1234};
    vecs[4]  = '{1'b1, 3'd0, 16'hFFFF, 3'd0, 16'h0000, 48'hA5A5_BEEF_1234};
    vecs[5]  = '{1'b1, 3'd6, 16'hFFFF, 3'd6, 16'h0000, 48'hA5A5_BEEF_1234};
    vecs[6]  = '{1'b1, 3'd7, 16'h5555, 3'd7, 16'h0000, 48'hA5A5_BEEF_1234};
    vecs[7]  = '{1'b0, 3'd2, 16'h9999, 3'd2, 16'h1234, 48'hA5A5_BEEF_1234};
    vecs[8]  = '{1'b1, 3'd5, 16'hFFFF, 3'd5, 16'h0000, 48'hA5A5_BEEF_1234};
    vecs[9]  = '{1'b1, 3'd3, 16'h0001, 3'd3, 16'h0001, 48'hA5A5_0001_1234};
    vecs[10] = '{1'b0, 3'd0, 16'h0000, 3'd1, 16'h0000, 48'hA5A5_0001_1234};

    #1;
    check("reset_oout", oout, 48'h0);
    for (int a = 0; a < 8; a++) check_rd($sformatf("reset_rd%0d", a), 3'(a), 16'h0);
    tick();
    rst = 1'b0;

    for (int v = 0; v < 11; v++) begin
      load    = vecs[v].ld;
      address = vecs[v].addr;
      wdata   = vecs[v].wdat;
      tick();
      load    = 1'b0;
      wdata   = '0;
      check_rd($sformatf("vec%0d_rd", v), vecs[v].rd_addr, vecs[v].exp_rd);
      check($sformatf("vec%0d_oout", v), oout, vecs[v].exp_oout);
    end

`ifdef IO_BANK_DEBOUNCE_EN
    for (int k = 0; k < 10; k++) begin
      iin = (k % 2 == 0) ? 32'h0000_0001 : 32'h0000_0000;
      tick();
      check_rd($sformatf("bounce%0d_val", k), 3'd0, 16'h0000);
    end
    iin = 32'h0000_0001;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e < 7) check_rd($sformatf("deb_edge%0d_val", e), 3'd0, 16'h0000);
      else begin
        check_rd("deb_accept_val", 3'd0, 16'h0001);
        check_rd("deb_accept_evt", 3'd5, 16'h0001);
      end
    end
`else
    iin = 32'h0000_0005;
    for (int e = 1; e <= 3; e++) begin
      tick();
      if (e < 3) begin
        check_rd($sformatf("in_edge%0d_val", e), 3'd0, 16'h0000);
        check_rd($sformatf("in_edge%0d_evt", e), 3'd5, 16'h0000);
      end else begin
        check_rd("in_edge3_val", 3'd0, 16'h0005);
        check_rd("in_edge3_evt", 3'd5, 16'h0001);
      end
    end

    load = 1'b1; address = 3'd5; wdata = 16'h0001;
    tick();
    load = 1'b0; wdata = '0;
    check_rd("evt_w1c", 3'd5, 16'h0000);

    iin = 32'h0000_0000;
    repeat (3) tick();
    check_rd("ch0_fall_val", 3'd0, 16'h0000);
    check_rd("ch0_fall_evt", 3'd5, 16'h0001);

    iin = 32'h00FF_0000;
    tick();
    tick();
    check_rd("pre_coll_evt", 3'd5, 16'h0001);
    check_rd("pre_coll_ch1", 3'd1, 16'h0000);
    load = 1'b1; address = 3'd5; wdata = 16'h0003;
    tick();
    load = 1'b0; wdata = '0;
    check_rd("coll_evt", 3'd5, 16'h0002);
    check_rd("coll_ch1", 3'd1, 16'h00FF);
`endif

    tick();
    rst = 1'b1;
    #1;
    check("midrst_oout", oout, 48'h0);
    for (int a = 0; a < 8; a++) check_rd($sformatf("midrst_rd%0d", a), 3'(a), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
